// File: rtl/part_4_adder_pkg.sv
// rtl/part_4_adder_pkg.sv - shared state encoding and helpers for the serial adder
package part_4_adder_pkg;

  // FSM encoding shared by the top level and anything that observes its state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for values of 0 or 1, callers clamp to a 1-bit minimum
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/part_4_chunk_adder.sv
// rtl/part_4_chunk_adder.sv - combinational CHUNK-bit adder slice with carry in/out
module part_4_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // One extra bit of headroom captures the carry out of the slice
  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/part_4_serial_adder.sv
// rtl/part_4_serial_adder.sv - multi-cycle add/subtract, CHUNK bits per clock
module part_4_serial_adder
  import part_4_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Reject geometries where the chunks would not tile the operand exactly
  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("part_4_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  state_e            state;
  state_e            state_next;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  sum_r;
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic              carry_out_r;
  logic              overflow_r;
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_c;

  // Select the operand slices for the chunk being processed this cycle
  always_comb begin
    chunk_a = a_r[idx*CHUNK +: CHUNK];
    chunk_b = b_r[idx*CHUNK +: CHUNK];
  end

  part_4_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // State register; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, step through chunks in RUN, hold DONE until consumed
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so no input reaches them combinationally
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, chunk-by-chunk accumulation and flag capture on the final chunk
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            sum_r <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_r[idx*CHUNK +: CHUNK] <= chunk_s;
          carry <= chunk_c;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // The top bit of the final chunk is the result sign bit
            carry_out_r <= chunk_c;
            overflow_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (chunk_s[CHUNK-1] != a_r[WIDTH-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum       = sum_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_part_4_serial_adder.sv
// tb/tb_part_4_serial_adder.sv - randomized self-checking bench for the serial adder
module tb_part_4_serial_adder;

  localparam int NI = 3;
  localparam int WID [NI] = '{32, 16, 8};
  localparam int NCH [NI] = '{4, 4, 1};

  logic        clk;
  logic        rst_v       [NI];
  logic        in_valid_v  [NI];
  logic        out_ready_v [NI];
  logic        sub_v       [NI];
  logic [31:0] a_v         [NI];
  logic [31:0] b_v         [NI];

  logic        in_ready_v  [NI];
  logic        out_valid_v [NI];
  logic        carry_v     [NI];
  logic        ovf_v       [NI];
  logic [31:0] sum_v       [NI];

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic        carry0, carry1, carry2;
  logic        ovf0, ovf1, ovf2;
  logic [31:0] sum0;
  logic [15:0] sum1;
  logic [7:0]  sum2;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  part_4_serial_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
    .a(a_v[0]), .b(b_v[0]), .sub(sub_v[0]), .out_valid(out_valid0),
    .out_ready(out_ready_v[0]), .sum(sum0), .carry_out(carry0), .overflow(ovf0)
  );

  part_4_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .sub(sub_v[1]), .out_valid(out_valid1),
    .out_ready(out_ready_v[1]), .sum(sum1), .carry_out(carry1), .overflow(ovf1)
  );

  part_4_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .sub(sub_v[2]), .out_valid(out_valid2),
    .out_ready(out_ready_v[2]), .sum(sum2), .carry_out(carry2), .overflow(ovf2)
  );

  // Gather the per-instance outputs into uniform 32-bit views
  always_comb begin
    in_ready_v[0]  = in_ready0;
    in_ready_v[1]  = in_ready1;
    in_ready_v[2]  = in_ready2;
    out_valid_v[0] = out_valid0;
    out_valid_v[1] = out_valid1;
    out_valid_v[2] = out_valid2;
    carry_v[0]     = carry0;
    carry_v[1]     = carry1;
    carry_v[2]     = carry2;
    ovf_v[0]       = ovf0;
    ovf_v[1]       = ovf1;
    ovf_v[2]       = ovf2;
    sum_v[0]       = sum0;
    sum_v[1]       = {16'h0, sum1};
    sum_v[2]       = {24'h0, sum2};
  end

  // Reference: plain integer arithmetic on w-bit unsigned and signed views
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] es,
                                output logic ec, output logic eo);
    longint mask, half, ua, ub, res, sa, sb, r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (s) begin
      res = (ua - ub) & mask;
      ec  = (ua >= ub);
    end else begin
      res = ua + ub;
      ec  = ((res >> w) & 1) != 0;
      res = res & mask;
    end
    es = 32'(res);
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    r  = s ? sa - sb : sa + sb;
    eo = (r >= half) || (r < -half);
  endfunction

  // One full operation with out_ready held high; caller is at a negedge with the DUT idle
  task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] es, input logic ec,
                       input logic eo, input string nm);
    int lat;
    checks++;
    if (in_ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s.in_ready inst%0d got %b want 1", nm, k, in_ready_v[k]);
    end
    a_v[k] = a;
    b_v[k] = b;
    sub_v[k] = s;
    in_valid_v[k] = 1'b1;
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a_v[k] = $urandom;
    b_v[k] = $urandom;
    sub_v[k] = 1'($urandom_range(0, 1));
    lat = 0;
    while (out_valid_v[k] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != NCH[k]) begin
      errors++;
      $display("FAIL %s.latency inst%0d got %0d want %0d", nm, k, lat, NCH[k]);
    end
    checks++;
    if (sum_v[k] !== es) begin
      errors++;
      $display("FAIL %s.sum inst%0d got %h want %h", nm, k, sum_v[k], es);
    end
    checks++;
    if (carry_v[k] !== ec) begin
      errors++;
      $display("FAIL %s.carry inst%0d got %b want %b", nm, k, carry_v[k], ec);
    end
    checks++;
    if (ovf_v[k] !== eo) begin
      errors++;
      $display("FAIL %s.overflow inst%0d got %b want %b", nm, k, ovf_v[k], eo);
    end
    @(negedge clk);
    checks++;
    if (out_valid_v[k] !== 1'b0 || in_ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s.consume inst%0d got valid=%b ready=%b want valid=0 ready=1",
               nm, k, out_valid_v[k], in_ready_v[k]);
    end
    checks++;
    if (sum_v[k] !== es) begin
      errors++;
      $display("FAIL %s.idle_hold inst%0d got %h want %h", nm, k, sum_v[k], es);
    end
  endtask

  task automatic do_model_op(input int k, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input string nm);
    logic [31:0] es;
    logic ec, eo;
    model(WID[k], a, b, s, es, ec, eo);
    do_op(k, a, b, s, es, ec, eo, nm);
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst_v[k] = 1'b1;
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b1;
      sub_v[k] = 1'b0;
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) rst_v[k] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (in_ready_v[k] !== 1'b1 || out_valid_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset.handshake inst%0d got ready=%b valid=%b want 1/0",
                 k, in_ready_v[k], out_valid_v[k]);
      end
      checks++;
      if (sum_v[k] !== 32'h0 || carry_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset.result inst%0d got sum=%h c=%b v=%b want 0/0/0",
                 k, sum_v[k], carry_v[k], ovf_v[k]);
      end
    end
  endtask

  task automatic test_directed_32();
    do_op(0, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0, 1'b0, "add_0_1");
    do_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, "ripple");
    do_op(0, 32'h0000_FFFF, 32'h0002_CCC1, 1'b0, 32'h0003_CCC0, 1'b0, 1'b0, "ripple2");
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap");
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
    do_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_scaled();
    do_model_op(1, 32'h00FF, 32'h0001, 1'b0, "w16_ripple");
    do_model_op(1, 32'h0FFF, 32'h2CC1, 1'b0, "w16_ripple2");
    do_model_op(1, 32'hFFFF, 32'h0001, 1'b0, "w16_wrap");
    do_model_op(1, 32'h7FFF, 32'h0001, 1'b0, "w16_pos_ovf");
    do_model_op(1, 32'h0005, 32'h0007, 1'b1, "w16_sub_borrow");
    do_model_op(1, 32'h8000, 32'h0001, 1'b1, "w16_sub_ovf");
    do_model_op(2, 32'h0F, 32'h01, 1'b0, "w8_add");
    do_model_op(2, 32'hFF, 32'h01, 1'b0, "w8_wrap");
    do_model_op(2, 32'h7F, 32'h01, 1'b0, "w8_pos_ovf");
    do_model_op(2, 32'h05, 32'h07, 1'b1, "w8_sub_borrow");
    do_model_op(2, 32'h80, 32'h01, 1'b1, "w8_sub_ovf");
  endtask

  // Back-to-back random ops at the minimum issue period on every geometry
  task automatic test_back_to_back();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 15; i++) begin
        do_model_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), "random");
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, es;
    logic s, ec, eo;
    int lat;
    a = $urandom;
    b = $urandom;
    s = 1'($urandom_range(0, 1));
    model(WID[0], a, b, s, es, ec, eo);
    out_ready_v[0] = 1'b0;
    a_v[0] = a;
    b_v[0] = b;
    sub_v[0] = s;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    lat = 0;
    while (out_valid_v[0] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != NCH[0]) begin
      errors++;
      $display("FAIL bp.latency got %0d want %0d", lat, NCH[0]);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp.hold_hs cycle%0d got valid=%b ready=%b want 1/0",
                 i, out_valid_v[0], in_ready_v[0]);
      end
      checks++;
      if (sum_v[0] !== es || carry_v[0] !== ec || ovf_v[0] !== eo) begin
        errors++;
        $display("FAIL bp.hold_result cycle%0d got %h/%b/%b want %h/%b/%b",
                 i, sum_v[0], carry_v[0], ovf_v[0], es, ec, eo);
      end
      in_valid_v[0] = 1'(i % 2);
      a_v[0] = $urandom;
      b_v[0] = $urandom;
      @(negedge clk);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp.release got valid=%b ready=%b want 0/1", out_valid_v[0], in_ready_v[0]);
    end
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) lat++;
    end
    checks++;
    if (lat != 0) begin
      errors++;
      $display("FAIL bp.no_ghost got %0d busy cycles want 0", lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "pre_reset");
    a_v[0] = 32'h1234_5678;
    b_v[0] = 32'h1111_1111;
    sub_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    checks++;
    if (sum_v[0] !== 32'h0 || carry_v[0] !== 1'b0 || ovf_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst.result got %h/%b/%b want 0/0/0", sum_v[0], carry_v[0], ovf_v[0]);
    end
    checks++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst.handshake got ready=%b valid=%b want 1/0",
               in_ready_v[0], out_valid_v[0]);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid_v[0] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst.no_valid got %0d valid cycles want 0", seen);
    end
    do_model_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)), "post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed_32();
    test_scaled();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
